joybus_tx_frame: RTL and testbench

- Parametrised Joybus transmitter for the fake N64 controller. It is the successor to the fixed-response controller TX path.
- Serialises a caller-supplied payload of 1..MAX_BYTES bytes, MSB first, using quarter-bit level encoding, then appends a configurable stop bit.
- Drives the open-drain data line through a single "pull low" output.
- Sits between the command decoder, which selects and loads the response, and the pad/RX logic, which takes the line back on done.

---
 rtl/joybus_tx_frame.sv | 156 +++++++++++++++
 tb/tb_joybus_tx_frame.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/joybus_tx_frame.sv
// Joybus frame transmitter: serialises 1..MAX_BYTES payload bytes MSB first with
// quarter-bit level encoding, then a stop bit, on an open-drain "pull low" output.
// Optional feature macro: JOYBUS_TX_ABORT_EN adds the abort input and aborted output.
module joybus_tx_frame #(
    parameter int unsigned LEVEL_WIDTH       = 2,
    parameter int unsigned MAX_BYTES         = 4,
    parameter int unsigned STOP_LOW_QUARTERS = 2
) (
    input  logic                               sample_clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [$clog2(MAX_BYTES+1)-1:0]     byte_count,
    input  logic [8*MAX_BYTES-1:0]             payload,
`ifdef JOYBUS_TX_ABORT_EN
    input  logic                               abort,
    output logic                               aborted,
`endif
    output logic                               busy,
    output logic                               done,
    output logic                               start_err,
    output logic                               line_low
);

    localparam int unsigned DATA_W = 8 * MAX_BYTES;
    localparam int unsigned BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned LVL_W  = (LEVEL_WIDTH > 1) ? $clog2(LEVEL_WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, DATA, STOP, DONE} state_t;

    state_t             state, state_nx;
    logic [LVL_W-1:0]   level_cnt, level_nx;
    logic [1:0]         quarter_cnt, quarter_nx;
    logic [BIT_W-1:0]   bit_cnt, bit_nx;
    logic [BIT_W-1:0]   last_bit, last_nx;
    logic [DATA_W-1:0]  shreg, shreg_nx;
    logic               busy_nx, done_nx, start_err_nx, line_low_nx;
    logic               level_end, quarter_end, count_ok;
    logic               abort_req, abort_hit;

`ifdef JOYBUS_TX_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // State, counters, latched payload and registered outputs
    always_ff @(posedge sample_clk) begin
        if (reset) begin
            state       <= IDLE;
            level_cnt   <= '0;
            quarter_cnt <= '0;
            bit_cnt     <= '0;
            last_bit    <= '0;
            shreg       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            start_err   <= 1'b0;
            line_low    <= 1'b0;
`ifdef JOYBUS_TX_ABORT_EN
            aborted     <= 1'b0;
`endif
        end else begin
            state       <= state_nx;
            level_cnt   <= level_nx;
            quarter_cnt <= quarter_nx;
            bit_cnt     <= bit_nx;
            last_bit    <= last_nx;
            shreg       <= shreg_nx;
            busy        <= busy_nx;
            done        <= done_nx;
            start_err   <= start_err_nx;
            line_low    <= line_low_nx;
`ifdef JOYBUS_TX_ABORT_EN
            aborted     <= abort_hit;
`endif
        end
    end

    // Next state, counter advance, and next output levels derived from the next state
    always_comb begin
        state_nx     = state;
        level_nx     = level_cnt;
        quarter_nx   = quarter_cnt;
        bit_nx       = bit_cnt;
        last_nx      = last_bit;
        shreg_nx     = shreg;
        start_err_nx = 1'b0;
        abort_hit    = 1'b0;
        busy_nx      = 1'b0;
        done_nx      = 1'b0;
        line_low_nx  = 1'b0;

        level_end   = (level_cnt == LVL_W'(LEVEL_WIDTH - 1));
        quarter_end = (quarter_cnt == 2'd3);
        count_ok    = (byte_count != '0) && (32'(byte_count) <= MAX_BYTES);

        if (state == DATA || state == STOP) begin
            if (level_end) begin
                level_nx   = '0;
                quarter_nx = quarter_cnt + 2'd1;
            end else begin
                level_nx   = level_cnt + LVL_W'(1);
            end
        end

        case (state)
            IDLE, DONE: begin
                // DONE lasts one cycle but accepts a back-to-back start like IDLE
                state_nx = IDLE;
                if (start && !abort_req) begin
                    if (count_ok) begin
                        state_nx   = DATA;
                        level_nx   = '0;
                        quarter_nx = '0;
                        bit_nx     = '0;
                        last_nx    = BIT_W'(32'({byte_count, 3'b000}) - 32'd1);
                        shreg_nx   = payload;
                    end else begin
                        start_err_nx = 1'b1;
                    end
                end
            end
            DATA: begin
                if (level_end && quarter_end) begin
                    if (bit_cnt == last_bit) begin
                        state_nx = STOP;
                    end else begin
                        bit_nx   = bit_cnt + BIT_W'(1);
                        shreg_nx = {shreg[DATA_W-2:0], 1'b0};
                    end
                end
            end
            STOP: begin
                if (level_end && quarter_end) begin
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase

        if (abort_req && (state == DATA || state == STOP)) begin
            state_nx  = IDLE;
            abort_hit = 1'b1;
        end

        busy_nx = (state_nx == DATA) || (state_nx == STOP);
        done_nx = (state_nx == DONE) || abort_hit;
        case (state_nx)
            DATA:    line_low_nx = (quarter_nx == 2'd0) ||
                                   (!shreg_nx[DATA_W-1] && quarter_nx != 2'd3);
            STOP:    line_low_nx = (32'(quarter_nx) < STOP_LOW_QUARTERS);
            default: line_low_nx = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_joybus_tx_frame.sv
// Directed bench for joybus_tx_frame: default geometry, LEVEL_WIDTH=1 geometry,
// rejected starts, back-to-back frames, mid-frame reset and (when built) abort.
module tb_joybus_tx_frame;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, start1;
    logic [2:0]  byte_count, byte_count1;
    logic [31:0] payload, payload1;
    logic        busy, done, start_err, line_low;
    logic        busy1, done1, start_err1, line_low1;
`ifdef JOYBUS_TX_ABORT_EN
    logic        abort, aborted, abort1, aborted1;
`endif

    int total = 0;
    int bad   = 0;

    logic tr_low  [0:300];
    logic tr_busy [0:300];
    logic tr_done [0:300];

    always #5 clk = ~clk;

    joybus_tx_frame #(.LEVEL_WIDTH(2), .MAX_BYTES(4), .STOP_LOW_QUARTERS(2)) dut (
        .sample_clk (clk),
        .reset      (reset),
        .start      (start),
        .byte_count (byte_count),
        .payload    (payload),
`ifdef JOYBUS_TX_ABORT_EN
        .abort      (abort),
        .aborted    (aborted),
`endif
        .busy       (busy),
        .done       (done),
        .start_err  (start_err),
        .line_low   (line_low)
    );

    joybus_tx_frame #(.LEVEL_WIDTH(1), .MAX_BYTES(4), .STOP_LOW_QUARTERS(2)) dut1 (
        .sample_clk (clk),
        .reset      (reset),
        .start      (start1),
        .byte_count (byte_count1),
        .payload    (payload1),
`ifdef JOYBUS_TX_ABORT_EN
        .abort      (abort1),
        .aborted    (aborted1),
`endif
        .busy       (busy1),
        .done       (done1),
        .start_err  (start_err1),
        .line_low   (line_low1)
    );

    // Expected line level in frame cycle c (cycle 1 = first level)
    function automatic logic exp_low(input logic [31:0] pl, input int nbytes, input int lw, input int c);
        int idx, bw, bn, q;
        idx = c - 1;
        bw  = 4 * lw;
        bn  = idx / bw;
        q   = (idx % bw) / lw;
        if (bn < 8 * nbytes) return (q == 0) || (!pl[31-bn] && q != 3);
        return (q < 2);
    endfunction

    // Runs one frame on dut whose start is already asserted in cycle 0
    task automatic frame0(input logic [2:0] bc, input logic [31:0] pl, input bit chain,
                          input logic [2:0] nbc, input logic [31:0] npl, input int mid);
        int len;
        logic e;
        len = 64 * int'(bc) + 8;
        for (int c = 1; c <= len + 1; c++) begin
            @(negedge clk);
            tr_low[c] = line_low; tr_busy[c] = busy; tr_done[c] = done;
            if (c == 1) begin start = 1'b0; byte_count = 3'd7; payload = ~pl; end
            if (c == mid) begin start = 1'b1; byte_count = 3'd1; payload = 32'h0; end
            if (c == mid + 1) start = 1'b0;
            if (c <= len) begin
                e = exp_low(pl, int'(bc), 2, c);
                total++; if (line_low !== e) begin bad++; $display("FAIL line_low c=%0d got=%b exp=%b", c, line_low, e); end
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy c=%0d got=%b exp=1", c, busy); end
                total++; if (done !== 1'b0 || start_err !== 1'b0) begin bad++; $display("FAIL no_pulse c=%0d done=%b err=%b exp=0", c, done, start_err); end
            end else begin
                total++; if (done !== 1'b1 || busy !== 1'b0 || line_low !== 1'b0) begin
                    bad++; $display("FAIL done_cycle c=%0d done=%b busy=%b low=%b exp=1/0/0", c, done, busy, line_low);
                end
                if (chain) begin start = 1'b1; byte_count = nbc; payload = npl; end
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; start1 = 1'b0;
        byte_count = '0; payload = '0; byte_count1 = '0; payload1 = '0;
`ifdef JOYBUS_TX_ABORT_EN
        abort = 1'b0; abort1 = 1'b0;
`endif
        repeat (3) @(negedge clk);
        total++; if ({busy, done, start_err, line_low} !== 4'b0) begin
            bad++; $display("FAIL reset_outs got=%b exp=0000", {busy, done, start_err, line_low});
        end
        total++; if ({busy1, done1, start_err1, line_low1} !== 4'b0) begin
            bad++; $display("FAIL reset_outs1 got=%b exp=0000", {busy1, done1, start_err1, line_low1});
        end
        reset = 1'b0;
    endtask

    task automatic test_default;
        @(negedge clk); byte_count = 3'd3; payload = 32'h0500_0000; start = 1'b1;
        frame0(3'd3, 32'h0500_0000, 1'b0, 3'd0, 32'h0, -1);
        // Hand-derived points: bit 0 low 1-6, bit 5 low 41-42, stop low 193-196
        total++; if (tr_low[1] !== 1'b1 || tr_low[6] !== 1'b1 || tr_low[7] !== 1'b0 || tr_low[8] !== 1'b0) begin
            bad++; $display("FAIL bit0_shape got=%b%b%b%b exp=1100", tr_low[1], tr_low[6], tr_low[7], tr_low[8]);
        end
        total++; if (tr_low[41] !== 1'b1 || tr_low[42] !== 1'b1 || tr_low[43] !== 1'b0 || tr_low[48] !== 1'b0) begin
            bad++; $display("FAIL bit5_shape got=%b%b%b%b exp=1100", tr_low[41], tr_low[42], tr_low[43], tr_low[48]);
        end
        total++; if (tr_low[57] !== 1'b1 || tr_low[59] !== 1'b0) begin
            bad++; $display("FAIL bit7_shape got=%b%b exp=10", tr_low[57], tr_low[59]);
        end
        total++; if (tr_low[193] !== 1'b1 || tr_low[196] !== 1'b1 || tr_low[197] !== 1'b0 || tr_low[200] !== 1'b0) begin
            bad++; $display("FAIL stop_shape got=%b%b%b%b exp=1100", tr_low[193], tr_low[196], tr_low[197], tr_low[200]);
        end
        total++; if (tr_done[201] !== 1'b1 || tr_busy[201] !== 1'b0 || tr_busy[200] !== 1'b1) begin
            bad++; $display("FAIL done_at_201 done=%b busy201=%b busy200=%b exp=1/0/1", tr_done[201], tr_busy[201], tr_busy[200]);
        end
        @(negedge clk);
        total++; if (done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL after_done done=%b busy=%b exp=0/0", done, busy);
        end
    endtask

    task automatic test_lw1;
        logic e;
        @(negedge clk); byte_count1 = 3'd4; payload1 = 32'hFFFF_FFFF; start1 = 1'b1;
        for (int c = 1; c <= 133; c++) begin
            @(negedge clk);
            if (c == 1) start1 = 1'b0;
            if (c <= 132) begin
                e = (c <= 128) ? ((c - 1) % 4 == 0) : (c <= 130);
                total++; if (line_low1 !== e || busy1 !== 1'b1 || done1 !== 1'b0) begin
                    bad++; $display("FAIL lw1_frame c=%0d low=%b busy=%b done=%b exp=%b/1/0", c, line_low1, busy1, done1, e);
                end
            end else begin
                total++; if (done1 !== 1'b1 || busy1 !== 1'b0 || line_low1 !== 1'b0) begin
                    bad++; $display("FAIL lw1_done c=%0d done=%b busy=%b low=%b exp=1/0/0", c, done1, busy1, line_low1);
                end
            end
        end
    endtask

    task automatic test_start_err;
        logic [2:0] bcs [0:1];
        bcs[0] = 3'd0; bcs[1] = 3'd5;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); byte_count = bcs[i]; payload = 32'hDEAD_BEEF; start = 1'b1;
            @(negedge clk); start = 1'b0;
            total++; if (start_err !== 1'b1 || busy !== 1'b0 || line_low !== 1'b0) begin
                bad++; $display("FAIL err_pulse bc=%0d err=%b busy=%b low=%b exp=1/0/0", bcs[i], start_err, busy, line_low);
            end
            @(negedge clk);
            total++; if (start_err !== 1'b0 || busy !== 1'b0 || line_low !== 1'b0) begin
                bad++; $display("FAIL err_once bc=%0d err=%b busy=%b low=%b exp=0/0/0", bcs[i], start_err, busy, line_low);
            end
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk); byte_count = 3'd1; payload = 32'h3C00_0000; start = 1'b1;
        frame0(3'd1, 32'h3C00_0000, 1'b1, 3'd2, 32'hC3A5_0000, -1);
        frame0(3'd2, 32'hC3A5_0000, 1'b0, 3'd0, 32'h0, 20);
        total++; if (tr_low[1] !== 1'b1 || tr_busy[1] !== 1'b1) begin
            bad++; $display("FAIL b2b_first low=%b busy=%b exp=1/1", tr_low[1], tr_busy[1]);
        end
    endtask

    task automatic test_reset_mid;
        logic e;
        @(negedge clk); byte_count = 3'd2; payload = 32'hA55A_0000; start = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            e = exp_low(32'hA55A_0000, 2, 2, c);
            total++; if (line_low !== e) begin bad++; $display("FAIL pre_reset c=%0d got=%b exp=%b", c, line_low, e); end
            if (c == 50) reset = 1'b1;
        end
        @(negedge clk); reset = 1'b0;
        total++; if (line_low !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL reset_mid low=%b busy=%b done=%b exp=0/0/0", line_low, busy, done);
        end
        for (int c = 52; c <= 60; c++) begin
            @(negedge clk);
            total++; if (done !== 1'b0 || busy !== 1'b0 || line_low !== 1'b0) begin
                bad++; $display("FAIL reset_quiet c=%0d done=%b busy=%b low=%b exp=0/0/0", c, done, busy, line_low);
            end
        end
        @(negedge clk); byte_count = 3'd1; payload = 32'h8100_0000; start = 1'b1;
        frame0(3'd1, 32'h8100_0000, 1'b0, 3'd0, 32'h0, -1);
    endtask

`ifdef JOYBUS_TX_ABORT_EN
    task automatic test_abort;
        @(negedge clk); byte_count = 3'd2; payload = 32'h1234_0000; start = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c <= 20) begin
                total++; if (busy !== 1'b1 || done !== 1'b0) begin
                    bad++; $display("FAIL pre_abort c=%0d busy=%b done=%b exp=1/0", c, busy, done);
                end
            end
            if (c == 20) abort = 1'b1;
            if (c == 21) begin
                abort = 1'b0;
                total++; if (line_low !== 1'b0 || done !== 1'b1 || aborted !== 1'b1 || busy !== 1'b0) begin
                    bad++; $display("FAIL abort_pulse low=%b done=%b aborted=%b busy=%b exp=0/1/1/0", line_low, done, aborted, busy);
                end
            end
            if (c > 21) begin
                total++; if (done !== 1'b0 || aborted !== 1'b0 || busy !== 1'b0) begin
                    bad++; $display("FAIL after_abort c=%0d done=%b aborted=%b busy=%b exp=0/0/0", c, done, aborted, busy);
                end
            end
        end
        @(negedge clk); byte_count = 3'd1; start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        total++; if (busy !== 1'b0 || start_err !== 1'b0 || line_low !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL abort_wins busy=%b err=%b low=%b done=%b exp=0/0/0/0", busy, start_err, line_low, done);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_default;
        test_lw1;
        test_start_err;
        test_back_to_back;
        test_reset_mid;
`ifdef JOYBUS_TX_ABORT_EN
        test_abort;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
